aes128_decrypt_iter: RTL and testbench

//  Iterative AES-128 decryptor: one round per clock, start/done handshake.

---
 rtl/aes128_decrypt_iter.sv | 238 +++++++++++++++++++++++
 tb/tb_aes128_decrypt_iter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_decrypt_iter.sv
`default_nettype none
// ============================================================================
//  Module      : aes128_decrypt_iter
//  Description : Iterative AES-128 decryptor, one round per clock. Expands the
//                forward cipher key to round key 10, then walks the schedule
//                backwards while decrypting. Optional cache of the last rk10.
//  Revision    : 1.0  initial release
// ============================================================================
module aes128_decrypt_iter #(
    parameter int KEY_CACHE = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic [127:0] ct_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] pt_out
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EXPAND = 3'd1,
        S_INIT   = 3'd2,
        S_ROUND  = 3'd3,
        S_FINAL  = 3'd4
    } state_t;

    state_t       r_state;
    logic [127:0] r_blk;          // working cipher state
    logic [127:0] r_key;          // current round key
    logic [127:0] r_cache_key;    // cipher key the cached rk10 belongs to
    logic [127:0] r_cache_rk10;
    logic         r_cache_valid;
    logic [3:0]   r_cnt;          // rcon index / round number

    // ------------------------------------------------------------------
    // GF(2^8) arithmetic, polynomial 0x11b
    // ------------------------------------------------------------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 by square-and-multiply; maps 0 to 0 naturally
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Key schedule: forward and inverse steps share one SubWord
    // ------------------------------------------------------------------
    logic [31:0]  w_sw_in;
    logic [31:0]  w_rot;
    logic [31:0]  w_sw_out;
    logic [31:0]  w_t;
    logic [31:0]  w_m0, w_m1, w_m2, w_m3;
    logic [31:0]  w_p3;
    logic [127:0] w_key_fwd;
    logic [127:0] w_key_inv;
    logic         w_cache_hit;

    // Forward step while expanding, inverse step otherwise; SubWord input is muxed
    always_comb begin
        w_sw_in  = (r_state == S_EXPAND) ? r_key[31:0] : (r_key[31:0] ^ r_key[63:32]);
        w_rot    = {w_sw_in[23:0], w_sw_in[31:24]};
        w_sw_out = '0;
        for (int i = 0; i < 4; i++) begin
            w_sw_out[8*i +: 8] = sbox(w_rot[8*i +: 8]);
        end
        w_t  = w_sw_out ^ {rcon(r_cnt), 24'h000000};
        w_m0 = r_key[127:96] ^ w_t;
        w_m1 = r_key[95:64]  ^ w_m0;
        w_m2 = r_key[63:32]  ^ w_m1;
        w_m3 = r_key[31:0]   ^ w_m2;
        w_key_fwd = {w_m0, w_m1, w_m2, w_m3};
        w_p3 = r_key[31:0] ^ r_key[63:32];
        w_key_inv = {r_key[127:96] ^ w_t,
                     r_key[95:64] ^ r_key[127:96],
                     r_key[63:32] ^ r_key[95:64],
                     w_p3};
        w_cache_hit = (KEY_CACHE != 0) && r_cache_valid && (key_in == r_cache_key);
    end

    // ------------------------------------------------------------------
    // Round datapath
    // ------------------------------------------------------------------
    logic [127:0] w_isr_isb;      // InvSubBytes(InvShiftRows(state))
    logic [127:0] w_ark;
    logic [127:0] w_round_out;

    // Byte k = column k/4, row k%4; row r rotates right by r positions
    always_comb begin
        w_isr_isb   = '0;
        w_round_out = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_isr_isb[127 - 8*(4*c + r) -: 8] =
                    inv_sbox(r_blk[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]);
            end
        end
        w_ark = w_isr_isb ^ r_key;
        for (int c = 0; c < 4; c++) begin
            w_round_out[127 - 32*c -: 32] = inv_mix_col(w_ark[127 - 32*c -: 32]);
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs and key cache
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            pt_out        <= '0;
            r_blk         <= '0;
            r_key         <= '0;
            r_cnt         <= 4'd0;
            r_cache_key   <= '0;
            r_cache_rk10  <= '0;
            r_cache_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_blk <= ct_in;
                        busy  <= 1'b1;
                        if (w_cache_hit) begin
                            r_key   <= r_cache_rk10;
                            r_cnt   <= 4'd10;
                            r_state <= S_INIT;
                        end else begin
                            // Tag is written now; valid only once rk10 is complete
                            r_key         <= key_in;
                            r_cnt         <= 4'd1;
                            r_cache_key   <= key_in;
                            r_cache_valid <= 1'b0;
                            r_state       <= S_EXPAND;
                        end
                    end
                end
                S_EXPAND: begin
                    r_key <= w_key_fwd;
                    if (r_cnt == 4'd10) begin
                        r_cache_rk10  <= w_key_fwd;
                        r_cache_valid <= 1'b1;
                        r_state       <= S_INIT;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_INIT: begin
                    r_blk   <= r_blk ^ r_key;
                    r_key   <= w_key_inv;
                    r_cnt   <= 4'd9;
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    r_blk <= w_round_out;
                    r_key <= w_key_inv;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_FINAL;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_FINAL: begin
                    pt_out  <= w_isr_isb ^ r_key;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes128_decrypt_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes128_decrypt_iter
//  Description : Self-checking bench for aes128_decrypt_iter: FIPS-197
//                vectors, key cache, held start, mid-op reset, no-cache
//                variant and random round trips through a reference encryptor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes128_decrypt_iter;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         start_nc = 1'b0;
    logic [127:0] key_in = '0;
    logic [127:0] ct_in = '0;
    logic         busy, done, busy_nc, done_nc;
    logic [127:0] pt_out, pt_out_nc;

    aes128_decrypt_iter #(.KEY_CACHE(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .key_in(key_in), .ct_in(ct_in),
        .busy(busy), .done(done), .pt_out(pt_out)
    );

    aes128_decrypt_iter #(.KEY_CACHE(0)) u_dut_nc (
        .clk(clk), .reset_n(reset_n), .start(start_nc), .key_in(key_in), .ct_in(ct_in),
        .busy(busy_nc), .done(done_nc), .pt_out(pt_out_nc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int t0 = 0;

    typedef struct {
        logic [127:0] pt;
        int           lat;
    } exp_t;
    exp_t sb[$];

    // ---------------- reference encryptor ----------------
    logic [7:0] sbox_t [256];

    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'b0000};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
                      ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int k = 0; k < 16; k++) s[k] = pt[127 - 8*k -: 8] ^ w[k/4][31 - 8*(k%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c + r] = sbox_t[s[4*((c + r) % 4) + r]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rnd < 10) begin
                    t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
                for (int r = 0; r < 4; r++)
                    s[4*c + r] = t[4*c + r] ^ w[4*rnd + c][31 - 8*r -: 8];
            end
        end
        for (int k = 0; k < 16; k++) res[127 - 8*k -: 8] = s[k];
        return res;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic issue(input logic [127:0] k, input logic [127:0] c,
                         input logic [127:0] p, input int lat);
        exp_t e;
        @(negedge clk);
        key_in = k;
        ct_in  = c;
        start  = 1'b1;
        e.pt = p;
        e.lat = lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        t0     = cyc;
        start  = 1'b0;
        key_in = ~k;                    // inputs are don't-care once latched
        ct_in  = {c[63:0], c[127:64]};
    endtask

    task automatic wait_done(input bit nc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if ((nc ? done_nc : done) === 1'b1) seen = 1'b1;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (pt_out !== 128'h0) begin errors++; $display("FAIL reset_pt: got %h want 0", pt_out); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fips_c1();
        exp_t e;
        bit   seen;
        issue(KEY1, CT1, PT1, 21);
        wait_done(1'b0, seen);
        e = sb.pop_front();
        checks++;
        if (!seen) begin
            errors++; $display("FAIL c1_done: no done within 40 cycles");
        end else begin
            checks++; if (pt_out !== e.pt) begin errors++; $display("FAIL c1_pt: got %h want %h", pt_out, e.pt); end
            checks++; if (cyc - t0 != e.lat) begin errors++; $display("FAIL c1_latency: got %0d want %0d", cyc - t0, e.lat); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL c1_busy_at_done: got %b want 0", busy); end
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL c1_done_pulse: got %b want 0", done); end
            checks++; if (pt_out !== e.pt) begin errors++; $display("FAIL c1_pt_hold: got %h want %h", pt_out, e.pt); end
        end
    endtask

    task automatic test_cache();
        exp_t e;
        bit   seen;
        issue(KEY1, CT1, PT1, 11);
        wait_done(1'b0, seen);
        e = sb.pop_front();
        checks++;
        if (!seen) begin errors++; $display("FAIL cache_hit_done: no done within 40 cycles"); end
        else begin
            checks++; if (pt_out !== e.pt) begin errors++; $display("FAIL cache_hit_pt: got %h want %h", pt_out, e.pt); end
            checks++; if (cyc - t0 != e.lat) begin errors++; $display("FAIL cache_hit_latency: got %0d want %0d", cyc - t0, e.lat); end
        end
        issue(KEY2, CT2, PT2, 21);
        wait_done(1'b0, seen);
        e = sb.pop_front();
        checks++;
        if (!seen) begin errors++; $display("FAIL appb_done: no done within 40 cycles"); end
        else begin
            checks++; if (pt_out !== e.pt) begin errors++; $display("FAIL appb_pt: got %h want %h", pt_out, e.pt); end
            checks++; if (cyc - t0 != e.lat) begin errors++; $display("FAIL appb_latency: got %0d want %0d", cyc - t0, e.lat); end
        end
    endtask

    // start held high for n blocks of the T1 vector on either instance
    task automatic test_stream(input bit nc, input int n, input int lat_first, input int lat_rest);
        exp_t e;
        bit   seen;
        int   extra;
        @(negedge clk);
        key_in = KEY1;
        ct_in  = CT1;
        if (nc) start_nc = 1'b1; else start = 1'b1;
        for (int b = 0; b < n; b++) begin
            e.pt  = PT1;
            e.lat = (b == 0) ? lat_first : lat_rest;
            sb.push_back(e);
        end
        for (int b = 0; b < n; b++) begin
            seen = 1'b0;
            for (int i = 0; i < 4 && !seen; i++) begin
                @(negedge clk);
                if ((nc ? busy_nc : busy) === 1'b1) seen = 1'b1;
            end
            t0 = cyc;
            e = sb.pop_front();
            checks++;
            if (!seen) begin errors++; $display("FAIL stream%0d_accept blk%0d: busy never rose", nc, b); end
            else begin
                wait_done(nc, seen);
                checks++;
                if (!seen) begin errors++; $display("FAIL stream%0d_done blk%0d: no done within 40 cycles", nc, b); end
                else begin
                    if (b == n - 1) begin start = 1'b0; start_nc = 1'b0; end
                    checks++;
                    if ((nc ? pt_out_nc : pt_out) !== e.pt) begin
                        errors++; $display("FAIL stream%0d_pt blk%0d: got %h want %h", nc, b, nc ? pt_out_nc : pt_out, e.pt);
                    end
                    checks++;
                    if (cyc - t0 != e.lat) begin
                        errors++; $display("FAIL stream%0d_latency blk%0d: got %0d want %0d", nc, b, cyc - t0, e.lat);
                    end
                end
            end
        end
        start = 1'b0;
        start_nc = 1'b0;
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if ((nc ? done_nc : done) === 1'b1 || (nc ? busy_nc : busy) === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL stream%0d_extra: got %0d active cycles after last block want 0", nc, extra); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   seen;
        int   late;
        @(negedge clk);
        key_in = KEY1;
        ct_in  = CT2;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b want 0", done); end
        checks++; if (pt_out !== 128'h0) begin errors++; $display("FAIL midreset_pt: got %h want 0", pt_out); end
        @(negedge clk);
        reset_n = 1'b1;
        late = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) late++;
        end
        checks++; if (late != 0) begin errors++; $display("FAIL midreset_no_done: got %0d done pulses want 0", late); end
        issue(KEY1, CT1, PT1, 21);
        wait_done(1'b0, seen);
        e = sb.pop_front();
        checks++;
        if (!seen) begin errors++; $display("FAIL postreset_done: no done within 40 cycles"); end
        else begin
            checks++; if (pt_out !== e.pt) begin errors++; $display("FAIL postreset_pt: got %h want %h", pt_out, e.pt); end
            checks++; if (cyc - t0 != e.lat) begin errors++; $display("FAIL postreset_latency: got %0d want %0d", cyc - t0, e.lat); end
        end
    endtask

    task automatic test_random();
        exp_t         e;
        bit           seen;
        logic [127:0] k, p;
        for (int n = 0; n < 6; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            issue(k, encrypt(k, p), p, 21);
            wait_done(1'b0, seen);
            e = sb.pop_front();
            checks++;
            if (!seen) begin errors++; $display("FAIL rand%0d_done: no done within 40 cycles", n); end
            else begin
                checks++; if (pt_out !== e.pt) begin errors++; $display("FAIL rand%0d_pt: got %h want %h", n, pt_out, e.pt); end
                checks++; if (cyc - t0 != e.lat) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", n, cyc - t0, e.lat); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        build_sbox();
        test_reset();
        test_fips_c1();
        test_cache();
        test_stream(1'b0, 3, 21, 11);
        test_reset_mid();
        test_stream(1'b1, 2, 21, 21);
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
